// File: rtl/sw_pkg.sv
// sw_pkg: shared state encoding and debounce constants for sw_debounce.
// Optional toggle output is enabled by defining SW_TOGGLE_EN.
package sw_pkg;
    typedef enum logic [1:0] {ST_LO, ST_WHI, ST_HI, ST_WLO} sw_state_t;
    localparam int DEBOUNCE_SIM   = 16;
    localparam int DEBOUNCE_BOARD = 1_000_000;
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction
endpackage

// File: rtl/sw_debounce_if.sv
// sw_debounce_if: raw switch inputs and conditioned outputs of sw_debounce.
// sw_toggle exists only when SW_TOGGLE_EN is defined.
interface sw_debounce_if #(parameter int NB_SW = 2);
    logic [NB_SW-1:0] sw_in, sw_level, sw_rise, sw_fall;
`ifdef SW_TOGGLE_EN
    logic [NB_SW-1:0] sw_toggle;
    modport master(output sw_in, input sw_level, sw_rise, sw_fall, sw_toggle);
    modport slave(input sw_in, output sw_level, sw_rise, sw_fall, sw_toggle);
`else
    modport master(output sw_in, input sw_level, sw_rise, sw_fall);
    modport slave(input sw_in, output sw_level, sw_rise, sw_fall);
`endif
endinterface

// File: rtl/sw_debounce_chan.sv
// sw_debounce_chan: synchroniser + hold-time FSM + edge pulses for one switch.
// Defining SW_TOGGLE_EN adds a flop that inverts on every rise pulse.
module sw_debounce_chan import sw_pkg::*; #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
    input  logic clk,
    input  logic nrst,
    input  logic sw_in,
    output logic level,
    output logic rise,
`ifdef SW_TOGGLE_EN
    output logic toggle,
`endif
    output logic fall
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0] cnt;
    sw_state_t state;
    logic sync;
    assign sync = sync_q[SYNC_STAGES-1];
    // level/rise/fall are loaded on the same edge as the qualifying transition
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            sync_q <= '0;
            cnt    <= '0;
            state  <= ST_LO;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_in};
            rise   <= 1'b0;
            fall   <= 1'b0;
            case (state)
                ST_LO:  if (sync) begin
                            state <= ST_WHI;
                            cnt   <= '0;
                        end
                ST_WHI: if (!sync) state <= ST_LO;
                        else begin
                            cnt <= cnt + 1'b1;
                            if (cnt == CNT_LAST) begin
                                state <= ST_HI;
                                level <= 1'b1;
                                rise  <= 1'b1;
                            end
                        end
                ST_HI:  if (!sync) begin
                            state <= ST_WLO;
                            cnt   <= '0;
                        end
                ST_WLO: if (sync) state <= ST_HI;
                        else begin
                            cnt <= cnt + 1'b1;
                            if (cnt == CNT_LAST) begin
                                state <= ST_LO;
                                level <= 1'b0;
                                fall  <= 1'b1;
                            end
                        end
            endcase
        end
`ifdef SW_TOGGLE_EN
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) toggle <= 1'b0;
        else toggle <= toggle ^ rise;
`endif
endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: NB_SW independent switch debounce channels behind sw_debounce_if.
// Define SW_TOGGLE_EN to add the per-channel sw_toggle output.
module sw_debounce import sw_pkg::*; #(
    parameter int NB_SW           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
    input logic clk,
    input logic nrst,
    sw_debounce_if.slave sw
);
    logic [NB_SW-1:0] level, rise, fall;
`ifdef SW_TOGGLE_EN
    logic [NB_SW-1:0] toggle;
    assign sw.sw_toggle = toggle;
`endif
    assign sw.sw_level = level;
    assign sw.sw_rise  = rise;
    assign sw.sw_fall  = fall;
    for (genvar i = 0; i < NB_SW; i++) begin : g_chan
        sw_debounce_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk(clk),
            .nrst(nrst),
            .sw_in(sw.sw_in[i]),
            .level(level[i]),
            .rise(rise[i]),
`ifdef SW_TOGGLE_EN
            .toggle(toggle[i]),
`endif
            .fall(fall[i])
        );
    end
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed + random check of sw_debounce against a run-length model.
// Covers sw_toggle when SW_TOGGLE_EN is defined.
module tb_sw_debounce;
    localparam int NB = 2, S = 2, D = 4;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    int checks = 0, failures = 0;
    always #10 clk = ~clk;

    sw_debounce_if #(.NB_SW(NB)) sw();
    sw_debounce #(.NB_SW(NB), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .nrst(nrst), .sw(sw));

    // level flips once the value seen S edges ago has differed from it for D+1 samples
    logic [NB-1:0] hist [S+D+1];
    logic [NB-1:0] m_level, m_rise, m_fall, m_tog;
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int j = 0; j <= S + D; j++) hist[j] = '0;
            m_level = '0; m_rise = '0; m_fall = '0; m_tog = '0;
        end else begin
            m_tog = m_tog ^ m_rise;
            for (int j = S + D; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = sw.sw_in;
            for (int c = 0; c < NB; c++) begin
                bit run;
                run = 1'b1;
                for (int j = S; j <= S + D; j++) if (hist[j][c] == m_level[c]) run = 1'b0;
                m_rise[c] = run && !m_level[c];
                m_fall[c] = run && m_level[c];
                if (run) m_level[c] = !m_level[c];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        chk("level", 32'(sw.sw_level), 32'(m_level));
        chk("rise", 32'(sw.sw_rise), 32'(m_rise));
        chk("fall", 32'(sw.sw_fall), 32'(m_fall));
        chk("rise_fall_excl", 32'(sw.sw_rise & sw.sw_fall), 32'd0);
`ifdef SW_TOGGLE_EN
        chk("toggle", 32'(sw.sw_toggle), 32'(m_tog));
`endif
    endtask

    task automatic lat(input int ch, input bit is_fall, input string tag);
        int n;
        n = -1;
        for (int i = 0; i < 20 && n < 0; i++) begin
            cyc();
            if (is_fall ? sw.sw_fall[ch] : sw.sw_rise[ch]) n = i;
        end
        chk(tag, 32'(n), 32'(S + D));
    endtask

    initial begin
        sw.sw_in = 2'b11;
        repeat (3) begin
            cyc();
            chk("in_reset", 32'({sw.sw_level, sw.sw_rise, sw.sw_fall}), 32'd0);
        end
        nrst = 1'b1;
        repeat (S + D) begin
            cyc();
            chk("post_reset", 32'({sw.sw_level, sw.sw_rise, sw.sw_fall}), 32'd0);
        end
        cyc();
        chk("simul_rise", 32'(sw.sw_rise), 32'b11);
`ifdef SW_TOGGLE_EN
        cyc();
        chk("toggle_first", 32'(sw.sw_toggle), 32'b11);
`endif
        sw.sw_in = 2'b00;
        repeat (12) cyc();
        sw.sw_in = 2'b11;
        repeat (12) cyc();
`ifdef SW_TOGGLE_EN
        chk("toggle_second", 32'(sw.sw_toggle), 32'b00);
`endif
        sw.sw_in = 2'b00;
        repeat (12) cyc();
        sw.sw_in[0] = 1'b1;
        repeat (3) cyc();
        sw.sw_in[0] = 1'b0;
        repeat (12) begin
            cyc();
            chk("glitch", 32'({sw.sw_level[0], sw.sw_rise[0], sw.sw_fall[0]}), 32'd0);
        end
        sw.sw_in[0] = 1'b1;
        lat(0, 1'b0, "press_lat");
        chk("press_level", 32'(sw.sw_level[0]), 32'd1);
        cyc();
        chk("press_rise_once", 32'(sw.sw_rise[0]), 32'd0);
        repeat (3) cyc();
        sw.sw_in[0] = 1'b0;
        lat(0, 1'b1, "release_lat");
        chk("release_level", 32'(sw.sw_level[0]), 32'd0);
        repeat (8) cyc();
        sw.sw_in[1] = 1'b1;
        repeat (2) cyc();
        nrst = 1'b0;
        cyc();
        chk("midrst_out", 32'({sw.sw_level, sw.sw_rise, sw.sw_fall}), 32'd0);
        nrst = 1'b1;
        lat(1, 1'b0, "midrst_lat");
        sw.sw_in = 2'b00;
        repeat (12) cyc();
        for (int n = 0; n < 800; n++) begin
            for (int c = 0; c < NB; c++)
                if ($urandom_range(7) == 0) sw.sw_in[c] = ~sw.sw_in[c];
            nrst = ($urandom_range(249) != 0);
            cyc();
        end
        nrst = 1'b1;
        repeat (12) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
